// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one synchronous single-port RAM between a write requester and a
//   read requester, and zero-fills addresses 0..CLR_LAST after reset or on
//   clr_start. Every memory-side output is registered. Grants are
//   combinational. Read data returns two cycles after the grant.
//
// Ports
//   CLK, RESETn          clock (rising edge) / async active-low reset
//   clr_start            one-cycle pulse, restarts the clear from address 0
//   wr_req/addr/data     write requester; wr_gnt accepts it this cycle
//   rd_req/addr          read requester; rd_gnt accepts it this cycle
//   rd_valid, rd_data    read return, valid two cycles after rd_gnt
//   busy                 clear sequence in progress
//   MEM_ADDR/WDATA/WRITEn registered RAM command (WRITEn active low)
//   MEM_RDATA            RAM read data, one cycle after the address
module mem_port_arbiter #(
  parameter int AW       = 11,
  parameter int DW       = 8,
  parameter int CLR_LAST = 338
) (
  input  logic          CLK,
  input  logic          RESETn,
  input  logic          clr_start,
  input  logic          wr_req,
  input  logic [AW-1:0] wr_addr,
  input  logic [DW-1:0] wr_data,
  output logic          wr_gnt,
  input  logic          rd_req,
  input  logic [AW-1:0] rd_addr,
  output logic          rd_gnt,
  output logic          rd_valid,
  output logic [DW-1:0] rd_data,
  output logic          busy,
  output logic [AW-1:0] MEM_ADDR,
  output logic [DW-1:0] MEM_WDATA,
  output logic          MEM_WRITEn,
  input  logic [DW-1:0] MEM_RDATA
);

  typedef enum logic {CLEAR, ARB} state_t;

  localparam logic          RR_WR   = 1'b0;
  localparam logic          RR_RD   = 1'b1;
  localparam logic [AW-1:0] CLR_END = AW'(CLR_LAST);
  localparam int            STAGES  = 1;

  state_t          state, state_nxt;
  logic [AW-1:0]   clr_addr, clr_addr_nxt;
  logic            rr_last, rr_last_nxt;
  logic [AW-1:0]   addr_nxt;
  logic [DW-1:0]   wdata_nxt;
  logic            writen_nxt;
  // [0]: command on the pins, [STAGES]: RAM data back
  logic [STAGES:0] vld_pipe;

  always_comb begin
    state_nxt    = state;
    clr_addr_nxt = clr_addr;
    rr_last_nxt  = rr_last;
    addr_nxt     = MEM_ADDR;
    wdata_nxt    = MEM_WDATA;
    writen_nxt   = 1'b1;
    wr_gnt       = 1'b0;
    rd_gnt       = 1'b0;
    case (state)
      CLEAR: begin
        addr_nxt   = clr_addr;
        wdata_nxt  = '0;
        writen_nxt = 1'b0;
        if (clr_addr == CLR_END) begin
          state_nxt    = ARB;
          clr_addr_nxt = '0;
        end else begin
          clr_addr_nxt = clr_addr + AW'(1);
        end
      end
      ARB: begin
        if (clr_start) begin
          state_nxt    = CLEAR;
          clr_addr_nxt = '0;
        end else if (wr_req && (!rd_req || rr_last == RR_RD)) begin
          wr_gnt = 1'b1;
        end else if (rd_req) begin
          rd_gnt = 1'b1;
        end
        if (wr_gnt) begin
          addr_nxt    = wr_addr;
          wdata_nxt   = wr_data;
          writen_nxt  = 1'b0;
          rr_last_nxt = RR_WR;
        end
        if (rd_gnt) begin
          addr_nxt    = rd_addr;
          rr_last_nxt = RR_RD;
        end
      end
      default: state_nxt = CLEAR;
    endcase
  end

  always_ff @(posedge CLK or negedge RESETn) begin
    if (!RESETn) begin
      state      <= CLEAR;
      clr_addr   <= '0;
      rr_last    <= RR_RD;
      MEM_ADDR   <= '0;
      MEM_WDATA  <= '0;
      MEM_WRITEn <= 1'b1;
      vld_pipe   <= '0;
    end else begin
      state      <= state_nxt;
      clr_addr   <= clr_addr_nxt;
      rr_last    <= rr_last_nxt;
      MEM_ADDR   <= addr_nxt;
      MEM_WDATA  <= wdata_nxt;
      MEM_WRITEn <= writen_nxt;
      // reads in flight complete regardless of a clear starting
      vld_pipe   <= {vld_pipe[STAGES-1:0], rd_gnt};
    end
  end

  assign rd_valid = vld_pipe[STAGES];
  assign rd_data  = MEM_RDATA;
  assign busy     = (state == CLEAR);

endmodule

// File: tb/tb_mem_port_arbiter.sv
module tb_mem_port_arbiter;
  localparam int AW = 11;
  localparam int DW = 8;
  localparam int CLR_LAST = 338;

  logic          CLK = 1'b0;
  logic          RESETn = 1'b0;
  logic          clr_start = 1'b0;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          wr_gnt;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic          rd_gnt;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          busy;
  logic [AW-1:0] MEM_ADDR;
  logic [DW-1:0] MEM_WDATA;
  logic          MEM_WRITEn;
  logic [DW-1:0] MEM_RDATA = '0;

  int checks = 0;
  int failures = 0;

  logic [DW-1:0] ram [0:(1<<AW)-1];

  mem_port_arbiter #(.AW(AW), .DW(DW), .CLR_LAST(CLR_LAST)) dut (
    .CLK(CLK), .RESETn(RESETn), .clr_start(clr_start),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt),
    .rd_valid(rd_valid), .rd_data(rd_data), .busy(busy),
    .MEM_ADDR(MEM_ADDR), .MEM_WDATA(MEM_WDATA), .MEM_WRITEn(MEM_WRITEn),
    .MEM_RDATA(MEM_RDATA)
  );

  always #5 CLK = ~CLK;

  // synchronous single-port RAM, read data one cycle after the address
  always @(posedge CLK) begin
    if (!MEM_WRITEn) ram[MEM_ADDR] <= MEM_WDATA;
    else             MEM_RDATA <= ram[MEM_ADDR];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(negedge CLK);
  endtask

  // called at the negedge right after reset release / clear entry
  task automatic clear_check(input string tag);
    int bad = 0;
    for (int k = 0; k <= CLR_LAST; k++) begin
      if (busy !== 1'b1 || wr_gnt !== 1'b0 || rd_gnt !== 1'b0) bad++;
      step();
      if (MEM_WRITEn !== 1'b0 || MEM_ADDR !== AW'(k) || MEM_WDATA !== '0) bad++;
    end
    chk({tag, "_seq_bad"}, bad, 0);
    chk({tag, "_busy_done"}, busy, 0);
  endtask

  initial begin
    int gnt_cnt;
    int found;
    for (int i = 0; i < (1<<AW); i++) ram[i] = 8'hFF;

    // reset state
    step();
    chk("rst_busy", busy, 1);
    chk("rst_writen", MEM_WRITEn, 1);
    chk("rst_addr", MEM_ADDR, 0);
    chk("rst_wdata", MEM_WDATA, 0);
    chk("rst_rdvalid", rd_valid, 0);
    wr_req = 1'b1; rd_req = 1'b1; #1;
    chk("rst_gnts", {wr_gnt, rd_gnt}, 0);
    wr_req = 1'b0; rd_req = 1'b0;
    RESETn = 1'b1;

    clear_check("clr1");

    // single write
    wr_req = 1'b1; wr_addr = 11'h005; wr_data = 8'hA5; #1;
    chk("wr_gnt", {wr_gnt, rd_gnt}, 2'b10);
    step();
    chk("wr_cmd", {MEM_WRITEn, MEM_ADDR, MEM_WDATA}, {1'b0, 11'h005, 8'hA5});
    wr_req = 1'b0;
    // read it back
    rd_req = 1'b1; rd_addr = 11'h005; #1;
    chk("rd_gnt", {wr_gnt, rd_gnt}, 2'b01);
    step();
    rd_req = 1'b0;
    chk("rd_cmd", {MEM_WRITEn, MEM_ADDR, MEM_WDATA}, {1'b1, 11'h005, 8'hA5});
    chk("rd_valid_early", rd_valid, 0);
    step();
    chk("rd_ret", {rd_valid, rd_data}, {1'b1, 8'hA5});
    step();
    chk("rd_valid_1wide", rd_valid, 0);
    chk("idle_hold", {MEM_WRITEn, MEM_ADDR, MEM_WDATA}, {1'b1, 11'h005, 8'hA5});

    // wrap-around address, write then read in consecutive grants
    wr_req = 1'b1; wr_addr = 11'h7FF; wr_data = 8'h3C;
    step();
    wr_req = 1'b0; rd_req = 1'b1; rd_addr = 11'h7FF;
    step();
    rd_req = 1'b0;
    step();
    chk("wr_rd_top", {rd_valid, rd_data}, {1'b1, 8'h3C});

    // both held: W,R,W,R,W,R
    wr_req = 1'b1; wr_addr = 11'h010; wr_data = 8'h11;
    rd_req = 1'b1; rd_addr = 11'h005;
    for (int i = 0; i < 6; i++) begin
      #1;
      chk($sformatf("rr_%0d", i), {wr_gnt, rd_gnt}, (i % 2 == 0) ? 2'b10 : 2'b01);
      step();
    end
    wr_req = 1'b0; rd_req = 1'b0;
    step(); step();

    // read granted just before clr_start
    rd_req = 1'b1; rd_addr = 11'h005; #1;
    chk("pre_clr_rd_gnt", rd_gnt, 1);
    step();
    wr_req = 1'b1; rd_req = 1'b1; clr_start = 1'b1; #1;
    gnt_cnt = (wr_gnt || rd_gnt) ? 1 : 0;
    step();
    clr_start = 1'b0;
    chk("clr_inflight_rd", {rd_valid, rd_data}, {1'b1, 8'hA5});
    chk("clr_busy_t1", {busy, MEM_WRITEn}, 2'b11);
    for (int k = 1; k <= CLR_LAST + 1; k++) begin
      #1;
      if (wr_gnt || rd_gnt || !busy) gnt_cnt++;
      if (k == 1) chk("clr_first_wr", {MEM_WRITEn}, 1);
      if (k == 2) chk("clr_first_pin", {MEM_WRITEn, MEM_ADDR}, {1'b0, 11'h000});
      step();
    end
    chk("clr_no_gnts", gnt_cnt, 0);
    #1;
    chk("clr_resume", {busy, wr_gnt, rd_gnt}, 3'b010);
    wr_req = 1'b0; rd_req = 1'b0;
    step();
    rd_req = 1'b1; rd_addr = 11'h005;
    step();
    rd_req = 1'b0;
    step();
    chk("clr_zeroed", {rd_valid, rd_data}, {1'b1, 8'h00});

    // reset in the middle of a clear
    clr_start = 1'b1;
    step();
    clr_start = 1'b0;
    found = 0;
    for (int k = 0; k < 400 && found == 0; k++) begin
      if (!MEM_WRITEn && MEM_ADDR == 11'd100) found = 1;
      else step();
    end
    chk("reach_clr100", found, 1);
    RESETn = 1'b0; #1;
    chk("async_rst", {busy, MEM_WRITEn, MEM_ADDR, MEM_WDATA, rd_valid},
        {1'b1, 1'b1, 11'h000, 8'h00, 1'b0});
    step();
    RESETn = 1'b1;
    clear_check("clr2");

    // read in flight cancelled by reset
    rd_req = 1'b1; rd_addr = 11'h005;
    step();
    rd_req = 1'b0;
    RESETn = 1'b0; #1;
    step();
    chk("rst_cancel_rd", rd_valid, 0);
    RESETn = 1'b1;
    step();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout got=running exp=finished");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/mem_port_arbiter.md
# mem_port_arbiter

Single-port RAM arbiter and clear sequencer for the pixel/result memory used by the calculator datapath. It shares one synchronous single-port RAM between a write requester (calculation side) and a read requester (display side), and it zero-fills the active region after reset or on command. All memory-side outputs are registered. Requesters use a same-cycle request/grant handshake, with read data returned at fixed latency.

## Interface
- AW, 11, memory address width
- DW, 8, memory data width
- CLR_LAST, 338, last address written by the clear sequence (clears 0..CLR_LAST inclusive)
- CLK  in  1  clock, rising edge
- RESETn  in  1  asynchronous, active-low reset
- clr_start  in  1  one-cycle pulse: start a new clear sequence
- wr_req  in  1  write request; held until granted
- wr_addr  in  AW  write address
- wr_data  in  DW  write data
- wr_gnt  out  1  write accepted this cycle (combinational)
- rd_req  in  1  read request; held until granted
- rd_addr  in  AW  read address
- rd_gnt  out  1  read accepted this cycle (combinational)
- rd_valid  out  1  rd_data valid (registered)
- rd_data  out  DW  read data, equal to MEM_RDATA while rd_valid=1
- busy  out  1  clear sequence in progress
- MEM_ADDR  out  AW  RAM address (registered)
- MEM_WDATA  out  DW  RAM write data (registered)
- MEM_WRITEn  out  1  RAM write enable, active-low (registered)
- MEM_RDATA  in  DW  RAM read data; valid one cycle after address is presented

## Operation
- States: CLEAR and ARB. Reset enters CLEAR with clr_addr=0 and rr_last=RD.
- CLEAR:
  - Each cycle, register a write of 0 to clr_addr, then increment clr_addr.
  - When clr_addr==CLR_LAST is issued, next state is ARB and clr_addr returns to 0.
  - wr_gnt=rd_gnt=0. clr_start is ignored. busy=1.
- ARB: busy=0.
  - Only wr_req: wr_gnt=1. Register MEM_ADDR=wr_addr, MEM_WDATA=wr_data, MEM_WRITEn=0.
  - Only rd_req: rd_gnt=1. Register MEM_ADDR=rd_addr, MEM_WRITEn=1.
  - Both requests: round-robin. Grant the requester that is not rr_last, then update rr_last to the granted one. Exactly one grant per cycle; neither requester waits more than 1 extra cycle.
  - No request: MEM_WRITEn=1; MEM_ADDR and MEM_WDATA hold their values.
  - clr_start=1: no grants that cycle, next state CLEAR from address 0. A clr_start that coincides with requests gives those requesters no grant.
- A read granted before a clear still completes: rd_valid asserts at its fixed latency even if the block is now in CLEAR.
- MEM_WDATA is don't-care on read cycles but holds its previous value.
- A requester may drop its request without being granted; no state is kept for ungranted requests.
- Address arithmetic is modulo 2^AW. Addresses are not range-checked.

## Timing
- Reset values: MEM_WRITEn=1, MEM_ADDR=0, MEM_WDATA=0, rd_valid=0, busy=1, wr_gnt=rd_gnt=0, state=CLEAR, rr_last=RD.
- After reset release, MEM_WRITEn=0 on edges 1..CLR_LAST+1, with MEM_ADDR=0..CLR_LAST in order (339 cycles by default).
- busy falls in the cycle after the last clear write is registered. Grants become possible in that same cycle.
- Grant in cycle t: the RAM command is visible in cycle t+1. For reads, rd_valid=1 and rd_data=MEM_RDATA in cycle t+2, one cycle wide per grant. Back-to-back reads give back-to-back rd_valid.
- Write-then-read to the same address in consecutive grants returns the new data.
- RESETn asserted mid-operation: all registers return to reset values immediately and asynchronously. In-flight rd_valid is cancelled, and the clear restarts from 0 after release.
- clr_start in cycle t (ARB): the first clear write appears on the memory pins at t+2; busy=1 from t+1.

## Test plan
- Reset release, no requests → exactly 339 writes with MEM_WDATA=0 to addresses 0..338; busy high for 339 cycles, then 0.
- After clear: wr_req with addr 0x005, data 0xA5 → wr_gnt same cycle; next cycle MEM_WRITEn=0, MEM_ADDR=0x005, MEM_WDATA=0xA5.
- Then rd_req with addr 0x005 → rd_gnt; two cycles later rd_valid=1, rd_data=0xA5 (RAM model).
- wr_req and rd_req both held for 6 cycles → grants W,R,W,R,W,R (writer first after reset); no cycle with both grants; no idle cycle.
- clr_start pulsed while both requests are held → no grants for 340 cycles (1 request cycle plus 339 clear cycles); a read granted the cycle before still returns rd_valid; arbitration resumes afterwards.
- RESETn pulsed low at clear address 100 → outputs return to reset values at once; the clear restarts at address 0 and takes the full 339 cycles.
